seven_seg_scan_driver: RTL



---
 rtl/seven_seg_scan_driver.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Operand-capture and digit-refresh front end for a four-digit
//   seven-segment display. Latches two 4-bit operands with their registered
//   sum/difference, and rotates a one-cold (active-low) anode select every
//   REFRESH_DIV enabled clock cycles.
//   Optional feature macro: SCAN_BLANK_EN -- when defined, anode is forced to
//   4'b1111 for the first BLANK_CYCLES cycles of every digit slot.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = $clog2(REFRESH_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       load,
  input  logic       enable,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] AplusB,
  output logic [3:0] AminusB,
  output logic       carry,
  output logic       borrow,
  output logic [3:0] anode,
  output logic       digit_tick
);

  // Reject parameter sets the counter and blanking logic cannot honour.
  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
    $error("seven_seg_scan_driver: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [3:0]       ANODE_RST = 4'b1111;
`else
  localparam logic [3:0]       ANODE_RST = 4'b1110;
`endif

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_state_e;

  digit_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       anode_q, anode_d;
  logic             tick_q, tick_d;

  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       sum_q, sum_d;
  logic [3:0]       diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic [4:0]       sum_full;

  // Active-low one-cold select for a digit state.
  function automatic logic [3:0] onecold(input digit_state_e s);
    case (s)
      D0:      onecold = 4'b1110;
      D1:      onecold = 4'b1101;
      D2:      onecold = 4'b1011;
      default: onecold = 4'b0111;
    endcase
  endfunction

  // Prescaler, digit sequencing and registered anode/tick next-state.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (state_q)
          D0:      state_d = D1;
          D1:      state_d = D2;
          D2:      state_d = D3;
          default: state_d = D0;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // anode is derived from the next count/state so it lines up with them.
    anode_d = onecold(state_d);
`ifdef SCAN_BLANK_EN
    if (cnt_d < CNT_BLANK) begin
      anode_d = 4'b1111;
    end
`endif
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= D0;
      cnt_q   <= '0;
      anode_q <= ANODE_RST;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  // Operand capture and arithmetic, computed from the inputs being latched so
  // the math outputs always match A/B.
  always_comb begin
    sum_full = {1'b0, a_in} + {1'b0, b_in};
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    if (load) begin
      a_d      = a_in;
      b_d      = b_in;
      sum_d    = sum_full[3:0];
      carry_d  = sum_full[4];
      diff_d   = a_in - b_in;
      borrow_d = (a_in < b_in);
    end
  end

  // Operand register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign AplusB     = sum_q;
  assign AminusB    = diff_q;
  assign carry      = carry_q;
  assign borrow     = borrow_q;
  assign anode      = anode_q;
  assign digit_tick = tick_q;

endmodule
